ysyx_22040088_mem_arbiter: RTL and testbench

- Arbitrates one shared memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the fetch/LSU stages and the memory/bus bridge.
- Strictly one transaction in flight.
- Request fields are registered on acceptance, so memory-side outputs never combinationally depend on requester inputs.

---
 rtl/ysyx_22040088_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ysyx_22040088_mem_arbiter.sv | 534 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040088_mem_arbiter.sv
// Shared memory-port arbiter between instruction fetch (read-only) and load/store.
// One transaction in flight; request fields are registered when a request is accepted.
module ysyx_22040088_mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 64,
    parameter int LSU_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [AW-1:0]     ifu_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DW-1:0]     ifu_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [AW-1:0]     lsu_addr,
    input  logic              lsu_wen,
    input  logic [DW-1:0]     lsu_wdata,
    input  logic [DW/8-1:0]   lsu_wmask,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DW-1:0]     lsu_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_wen,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wmask,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [DW-1:0]     mem_rdata,

    output logic              grant_lsu
);
    localparam int MW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            grant_lsu_q, grant_lsu_d;
    logic            last_lsu_q, last_lsu_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]   wmask_q, wmask_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            pick_lsu;
    logic            pick_ifu;
    logic            idle_open;
    logic            owner_rsp_ready;

    // Tie-break: fixed LSU priority, or whichever side was not granted last.
    always_comb begin
        pick_lsu = lsu_req_valid && (!ifu_req_valid || (LSU_PRIO != 0) || !last_lsu_q);
        pick_ifu = ifu_req_valid && !pick_lsu;
    end

    // Readiness is also held low while reset is asserted.
    assign idle_open       = (state_q == S_IDLE) && !rst;
    assign owner_rsp_ready = grant_lsu_q ? lsu_rsp_ready : ifu_rsp_ready;

    always_comb begin
        state_d     = state_q;
        grant_lsu_d = grant_lsu_q;
        last_lsu_d  = last_lsu_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (idle_open && pick_lsu) begin
                    addr_d      = lsu_addr;
                    wen_d       = lsu_wen;
                    wdata_d     = lsu_wdata;
                    wmask_d     = lsu_wmask;
                    grant_lsu_d = 1'b1;
                    last_lsu_d  = 1'b1;
                    state_d     = S_REQ;
                end else if (idle_open && pick_ifu) begin
                    addr_d      = ifu_addr;
                    wen_d       = 1'b0;
                    wdata_d     = '0;
                    wmask_d     = '0;
                    grant_lsu_d = 1'b0;
                    last_lsu_d  = 1'b0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (owner_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_lsu_q <= 1'b0;
            last_lsu_q  <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_lsu_q <= grant_lsu_d;
            last_lsu_q  <= last_lsu_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ifu_req_ready = idle_open && pick_ifu;
    assign lsu_req_ready = idle_open && pick_lsu;

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_rsp_ready = (state_q == S_WAIT);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign ifu_rsp_valid = (state_q == S_RESP) && !grant_lsu_q;
    assign lsu_rsp_valid = (state_q == S_RESP) &&  grant_lsu_q;
    assign ifu_rdata     = grant_lsu_q ? '0 : rdata_q;
    assign lsu_rdata     = grant_lsu_q ? rdata_q : '0;

    assign grant_lsu     = grant_lsu_q;

endmodule

// File: tb/tb_ysyx_22040088_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: fixed-priority instance plus a round-robin instance.
module tb_ysyx_22040088_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Fixed LSU-priority instance
    logic            ifu_req_valid = 1'b0, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready = 1'b1;
    logic [AW-1:0]   ifu_addr = '0;
    logic [DW-1:0]   ifu_rdata;
    logic            lsu_req_valid = 1'b0, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready = 1'b1;
    logic [AW-1:0]   lsu_addr = '0;
    logic            lsu_wen = 1'b0;
    logic [DW-1:0]   lsu_wdata = '0;
    logic [MW-1:0]   lsu_wmask = '0;
    logic [DW-1:0]   lsu_rdata;
    logic            mem_req_valid, mem_req_ready = 1'b0, mem_wen;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [MW-1:0]   mem_wmask;
    logic            mem_rsp_valid = 1'b0, mem_rsp_ready;
    logic [DW-1:0]   mem_rdata = '0;
    logic            grant_lsu;

    // Round-robin instance with an always-ready memory and requesters
    logic            rr_ifu_req_valid = 1'b0, rr_ifu_req_ready, rr_ifu_rsp_valid;
    logic [DW-1:0]   rr_ifu_rdata;
    logic            rr_lsu_req_valid = 1'b0, rr_lsu_req_ready, rr_lsu_rsp_valid;
    logic [DW-1:0]   rr_lsu_rdata;
    logic            rr_mem_req_valid, rr_mem_wen, rr_mem_rsp_ready;
    logic [AW-1:0]   rr_mem_addr;
    logic [DW-1:0]   rr_mem_wdata;
    logic [MW-1:0]   rr_mem_wmask;
    logic            rr_grant_lsu;
    logic            rr_one = 1'b1;
    logic            rr_zero = 1'b0;
    logic [AW-1:0]   rr_ifu_addr = 32'h0000_1000;
    logic [AW-1:0]   rr_lsu_addr = 32'h0000_2000;
    logic [DW-1:0]   rr_wdata = '0;
    logic [MW-1:0]   rr_wmask = '0;
    logic [DW-1:0]   rr_mem_rdata = 64'h1111_2222_3333_4444;

    typedef struct packed {
        logic          lsu;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    ysyx_22040088_mem_arbiter #(.AW(AW), .DW(DW), .LSU_PRIO(1)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
        .grant_lsu(grant_lsu)
    );

    ysyx_22040088_mem_arbiter #(.AW(AW), .DW(DW), .LSU_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst),
        .ifu_req_valid(rr_ifu_req_valid), .ifu_req_ready(rr_ifu_req_ready), .ifu_addr(rr_ifu_addr),
        .ifu_rsp_valid(rr_ifu_rsp_valid), .ifu_rsp_ready(rr_one), .ifu_rdata(rr_ifu_rdata),
        .lsu_req_valid(rr_lsu_req_valid), .lsu_req_ready(rr_lsu_req_ready), .lsu_addr(rr_lsu_addr),
        .lsu_wen(rr_zero), .lsu_wdata(rr_wdata), .lsu_wmask(rr_wmask),
        .lsu_rsp_valid(rr_lsu_rsp_valid), .lsu_rsp_ready(rr_one), .lsu_rdata(rr_lsu_rdata),
        .mem_req_valid(rr_mem_req_valid), .mem_req_ready(rr_one), .mem_addr(rr_mem_addr),
        .mem_wen(rr_mem_wen), .mem_wdata(rr_mem_wdata), .mem_wmask(rr_mem_wmask),
        .mem_rsp_valid(rr_one), .mem_rsp_ready(rr_mem_rsp_ready), .mem_rdata(rr_mem_rdata),
        .grant_lsu(rr_grant_lsu)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in REQ: zero-wait memory handshake and response; returns in RESP.
    task automatic mem_serve(input logic owner, input logic [DW-1:0] data, output logic any_ready);
        exp_t e;
        any_ready = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        any_ready = any_ready | ifu_req_ready | lsu_req_ready;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = data;
        e.lsu = owner;
        e.data = data;
        sb_q.push_back(e);
        @(negedge clk);
        any_ready = any_ready | ifu_req_ready | lsu_req_ready;
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready,
             ifu_rsp_valid, lsu_rsp_valid, grant_lsu} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready,
                      ifu_rsp_valid, lsu_rsp_valid, grant_lsu});
        end
        checks++;
        if (mem_addr !== '0 || mem_wen !== 1'b0 || mem_wdata !== '0 || mem_wmask !== '0) begin
            errors++;
            $display("FAIL reset_fields: addr=%h wen=%b wdata=%h wmask=%h required all zero",
                     mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        checks++;
        if (ifu_rdata !== '0 || lsu_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: ifu=%h lsu=%h required 0", ifu_rdata, lsu_rdata);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_ifu_read();
        exp_t e;
        int   t0;
        ifu_addr = 32'h8000_0000;
        ifu_req_valid = 1'b1;
        ifu_rsp_ready = 1'b1;
        @(negedge clk);
        t0 = cyc_cnt;
        checks++;
        if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ifu_accept: ifu_ready=%b lsu_ready=%b required 1/0", ifu_req_ready, lsu_req_ready);
        end
        step();
        ifu_req_valid = 1'b0;
        ifu_addr = 32'h1234_5678;
        mem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || (cyc_cnt - t0) != 1 || mem_addr !== 32'h8000_0000 ||
            mem_wen !== 1'b0 || mem_wmask !== 8'h00 || grant_lsu !== 1'b0) begin
            errors++;
            $display("FAIL ifu_memreq: valid=%b cycle=%0d addr=%h wen=%b wmask=%h grant=%b required 1/1/80000000/0/00/0",
                     mem_req_valid, cyc_cnt - t0, mem_addr, mem_wen, mem_wmask, grant_lsu);
        end
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'h0000_0013_0000_0093;
        e.lsu = 1'b0;
        e.data = 64'h0000_0013_0000_0093;
        sb_q.push_back(e);
        @(negedge clk);
        checks++;
        if (mem_rsp_ready !== 1'b1 || ifu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ifu_wait: mem_rsp_ready=%b ifu_rsp_valid=%b required 1/0", mem_rsp_ready, ifu_rsp_valid);
        end
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        checks++;
        if (ifu_rsp_valid !== 1'b1 || lsu_rsp_valid !== 1'b0 || (cyc_cnt - t0) != 3 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL ifu_rsp_valid: ifu=%b lsu=%b cycle=%0d queued=%0d required 1/0/3/>0",
                     ifu_rsp_valid, lsu_rsp_valid, cyc_cnt - t0, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (ifu_rdata !== e.data || e.lsu !== 1'b0 || lsu_rdata !== '0) begin
                errors++;
                $display("FAIL ifu_rdata: got %h lsu_rdata=%h required %h / 0", ifu_rdata, lsu_rdata, e.data);
            end
        end
        step();
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0004;
        @(negedge clk);
        checks++;
        if (ifu_req_ready !== 1'b1 || (cyc_cnt - t0) != 4) begin
            errors++;
            $display("FAIL ifu_next_accept: ready=%b cycle=%0d required 1/4", ifu_req_ready, cyc_cnt - t0);
        end
        ifu_req_valid = 1'b0;
        step();
    endtask

    task automatic test_priority();
        exp_t e;
        logic busy;
        ifu_addr = 32'h8000_0040;
        lsu_addr = 32'h8000_2000;
        lsu_wen = 1'b0;
        lsu_wmask = 8'h00;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_select: lsu_ready=%b ifu_ready=%b required 1/0", lsu_req_ready, ifu_req_ready);
        end
        step();
        lsu_req_valid = 1'b0;
        lsu_addr = 32'h0;
        @(negedge clk);
        checks++;
        if (grant_lsu !== 1'b1 || mem_addr !== 32'h8000_2000 || mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL prio_lsu_req: grant=%b addr=%h wen=%b required 1/80002000/0", grant_lsu, mem_addr, mem_wen);
        end
        mem_serve(1'b1, 64'hAAAA_0000_BBBB_0001, busy);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ifu_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_ifu_blocked: ready seen=%b now=%b required 0/0", busy, ifu_req_ready);
        end
        checks++;
        if (lsu_rsp_valid !== 1'b1 || ifu_rsp_valid !== 1'b0 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL prio_lsu_rsp: lsu=%b ifu=%b queued=%0d required 1/0/>0", lsu_rsp_valid, ifu_rsp_valid, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (e.lsu !== 1'b1 || lsu_rdata !== e.data || grant_lsu !== 1'b1) begin
                errors++;
                $display("FAIL prio_lsu_data: got %h grant=%b required %h owner=%b", lsu_rdata, grant_lsu, e.data, e.lsu);
            end
        end
        step();
        @(negedge clk);
        checks++;
        if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_ifu_next: ifu_ready=%b lsu_ready=%b required 1/0", ifu_req_ready, lsu_req_ready);
        end
        step();
        ifu_req_valid = 1'b0;
        mem_serve(1'b0, 64'h0000_0513_0000_0297, busy);
        @(negedge clk);
        checks++;
        if (ifu_rsp_valid !== 1'b1 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL prio_ifu_rsp: ifu_rsp_valid=%b queued=%0d required 1/>0", ifu_rsp_valid, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (e.lsu !== 1'b0 || ifu_rdata !== e.data || grant_lsu !== 1'b0) begin
                errors++;
                $display("FAIL prio_ifu_data: got %h grant=%b required %h owner=%b", ifu_rdata, grant_lsu, e.data, e.lsu);
            end
        end
        step();
    endtask

    task automatic test_round_robin();
        logic rr_q[$];
        logic exp_lsu;
        int   last_acc;
        last_acc = -1;
        rr_q.push_back(1'b1);
        rr_q.push_back(1'b0);
        rr_q.push_back(1'b1);
        rr_q.push_back(1'b0);
        rr_ifu_req_valid = 1'b1;
        rr_lsu_req_valid = 1'b1;
        for (int i = 0; i < 40 && rr_q.size() > 0; i++) begin
            @(negedge clk);
            if (rr_ifu_req_ready || rr_lsu_req_ready) begin
                exp_lsu = rr_q.pop_front();
                checks++;
                if (rr_lsu_req_ready !== exp_lsu || rr_ifu_req_ready !== !exp_lsu) begin
                    errors++;
                    $display("FAIL rr_grant: lsu_ready=%b ifu_ready=%b required lsu=%b", rr_lsu_req_ready, rr_ifu_req_ready, exp_lsu);
                end
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc_cnt - last_acc != 4) begin
                        errors++;
                        $display("FAIL rr_period: got %0d cycles required 4", cyc_cnt - last_acc);
                    end
                end
                last_acc = cyc_cnt;
            end
            step();
        end
        rr_ifu_req_valid = 1'b0;
        rr_lsu_req_valid = 1'b0;
        checks++;
        if (rr_q.size() != 0) begin
            errors++;
            $display("FAIL rr_timeout: %0d grants missing required 0", rr_q.size());
        end
        repeat (4) step();
    endtask

    task automatic test_store();
        exp_t e;
        int   held;
        logic stable;
        lsu_addr = 32'h8000_1000;
        lsu_wdata = 64'hDEAD_BEEF_0000_1234;
        lsu_wmask = 8'h0F;
        lsu_wen = 1'b1;
        lsu_req_valid = 1'b1;
        lsu_rsp_ready = 1'b1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (lsu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_accept: lsu_ready=%b required 1", lsu_req_ready);
        end
        step();
        lsu_req_valid = 1'b0;
        lsu_addr = 32'h0;
        lsu_wdata = '1;
        lsu_wmask = 8'hF0;
        lsu_wen = 1'b0;
        held = 0;
        stable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_req_ready = (k == 3);
            @(negedge clk);
            if (mem_req_valid === 1'b1) held++;
            if (mem_addr !== 32'h8000_1000 || mem_wdata !== 64'hDEAD_BEEF_0000_1234 ||
                mem_wmask !== 8'h0F || mem_wen !== 1'b1) stable = 1'b0;
            step();
        end
        mem_req_ready = 1'b0;
        checks++;
        if (held != 4) begin
            errors++;
            $display("FAIL store_req_hold: got %0d cycles required 4", held);
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL store_fields: addr=%h wdata=%h wmask=%h wen=%b required 80001000/deadbeef00001234/0f/1",
                     mem_addr, mem_wdata, mem_wmask, mem_wen);
        end
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b0 || mem_rsp_ready !== 1'b1 || lsu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_wait: req_valid=%b rsp_ready=%b lsu_rsp_valid=%b required 0/1/0",
                     mem_req_valid, mem_rsp_ready, lsu_rsp_valid);
        end
        step();
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'hCAFE_F00D_5555_AAAA;
        e.lsu = 1'b1;
        e.data = 64'hCAFE_F00D_5555_AAAA;
        sb_q.push_back(e);
        @(negedge clk);
        checks++;
        if (lsu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_rsp_early: lsu_rsp_valid=%b required 0", lsu_rsp_valid);
        end
        step();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (lsu_rsp_valid !== 1'b1 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL store_ack: lsu_rsp_valid=%b queued=%0d required 1/>0", lsu_rsp_valid, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (e.lsu !== 1'b1 || lsu_rdata !== e.data || grant_lsu !== 1'b1) begin
                errors++;
                $display("FAIL store_ack_data: got %h grant=%b required %h/1", lsu_rdata, grant_lsu, e.data);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic busy;
        lsu_addr = 32'h8000_3000;
        lsu_wen = 1'b0;
        lsu_wmask = 8'h00;
        lsu_req_valid = 1'b1;
        lsu_rsp_ready = 1'b0;
        step();
        ifu_req_valid = 1'b1;
        mem_serve(1'b1, 64'h0123_4567_89AB_CDEF, busy);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0 || lsu_rsp_valid !== 1'b1 || lsu_rdata !== sb_q[0].data ||
                ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: rsp_valid=%b rdata=%h ifu_ready=%b lsu_ready=%b required 1/0123456789abcdef/0/0",
                         k, lsu_rsp_valid, lsu_rdata, ifu_req_ready, lsu_req_ready);
            end
            step();
        end
        lsu_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (lsu_rsp_valid !== 1'b1 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL bp_release: rsp_valid=%b queued=%0d required 1/>0", lsu_rsp_valid, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (lsu_rdata !== e.data || e.lsu !== 1'b1) begin
                errors++;
                $display("FAIL bp_data: got %h required %h", lsu_rdata, e.data);
            end
        end
        lsu_req_valid = 1'b0;
        ifu_req_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic bad;
        logic busy;
        ifu_addr = 32'h8000_0100;
        ifu_req_valid = 1'b1;
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_rsp_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_wait: mem_rsp_ready=%b required 1", mem_rsp_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid,
             lsu_rsp_valid, grant_lsu} !== 7'b0 || mem_addr !== '0 || mem_wmask !== '0 ||
            ifu_rdata !== '0 || lsu_rdata !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: ctrl=%b addr=%h required 0000000/00000000",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid,
                      lsu_rsp_valid, grant_lsu}, mem_addr);
        end
        step();
        rst = 1'b0;
        step();
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bad = bad | ifu_rsp_valid | lsu_rsp_valid | mem_rsp_ready;
            step();
            mem_rsp_valid = 1'b0;
        end
        checks++;
        if (bad !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_stale: response seen=%b queued=%0d required 0/0", bad, sb_q.size());
        end
        ifu_addr = 32'h8000_0200;
        ifu_req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_accept: ifu_ready=%b required 1", ifu_req_ready);
        end
        step();
        ifu_req_valid = 1'b0;
        mem_serve(1'b0, 64'h0000_0073_0010_0513, busy);
        @(negedge clk);
        checks++;
        if (ifu_rsp_valid !== 1'b1 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL rstmid_rsp: ifu_rsp_valid=%b queued=%0d required 1/>0", ifu_rsp_valid, sb_q.size());
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (ifu_rdata !== e.data || e.lsu !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_data: got %h required %h", ifu_rdata, e.data);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_ifu_read();
        test_priority();
        test_store();
        test_backpressure();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
